// File: rtl/acia_rx_feeder_pkg.sv
// Shared types and constants for the ACIA receive feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   rx_state_e           feeder FSM states (IDLE/POP/PACE)
//   STAT_*_BIT           6850 status register bit positions for the register mux
//   BYTE_CYCLES_DEFAULT  10 bit times at 7812.5 baud with a 32 MHz out_clk
//   pace_width()         counter width needed for a given character time
package acia_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PACE = 2'd2
  } rx_state_e;

  localparam int STAT_RDRF_BIT = 0;
  localparam int STAT_OVRN_BIT = 5;
  localparam int STAT_IRQ_BIT  = 7;

  localparam int BYTE_CYCLES_DEFAULT = 40960;

  // Never narrower than one bit, so a minimal BYTE_CYCLES=2 still builds.
  function automatic int pace_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/acia_rx_feeder_if.sv
// Bundle between the feeder, the IO-controller FIFO read port and the ACIA CPU side.
// Latency: n/a (wires only).
// Backpressure: fifo_pop is the only flow control; the FIFO never sees a pop while empty.
//
// master: the feeder (drives fifo_pop and the receive register/flags)
// slave : the environment (FIFO head, CPU control strobes)
interface acia_rx_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  import acia_rx_pkg::*;

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_available;
  logic                  fifo_pop;
  logic                  master_reset;
  logic                  cpu_rd_data;
  logic                  irq_enable;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rdrf;
  logic                  ovrn;
  logic                  irq;

  modport master (
    input  fifo_data, fifo_available, master_reset, cpu_rd_data, irq_enable,
    output fifo_pop, rx_data, rdrf, ovrn, irq
  );

  modport slave (
    output fifo_data, fifo_available, master_reset, cpu_rd_data, irq_enable,
    input  fifo_pop, rx_data, rdrf, ovrn, irq
  );

endinterface

// File: rtl/acia_rx_feeder_byte_pacer.sv
// Loadable down-counter that enforces the emulated serial character time.
// Latency: load/decrement visible the cycle after the request.
// Backpressure: none; the caller decides when to load and decrement.
//
// Ports:
//   out_clk, reset  clock, synchronous active-high reset
//   clear_i         synchronous clear (ACIA master reset), wins over load/dec
//   load_i          load BYTE_CYCLES-2
//   dec_i           decrement, saturating at zero
//   zero_o          counter is zero now
//   last_o          counter will be zero after this cycle's decrement
module byte_pacer
  import acia_rx_pkg::*;
#(
  parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
  input  logic out_clk,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o,
  output logic last_o
);

  localparam int CW = pace_width(BYTE_CYCLES);
  // The POP cycle and the PACE->IDLE cycle account for the other two cycles.
  localparam logic [CW-1:0] LOAD_VAL = CW'(BYTE_CYCLES - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge out_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q <= ONE);

endmodule

// File: rtl/acia_rx_feeder.sv
// Pops the IO-controller byte FIFO into a 6850-style receive register at UART pace.
// Latency: fifo_available -> fifo_pop 1 cycle -> rdrf/rx_data 2 cycles; pops >= BYTE_CYCLES apart.
// Backpressure: ALLOW_OVERRUN=0 holds pops while rdrf=1; =1 pops on schedule and flags overrun.
//
// Ports:
//   out_clk        clock, shared with the FIFO read side
//   reset          synchronous active-high; clears everything including rx_data
//   bus (master)   FIFO head/available/pop, ACIA master_reset, cpu_rd_data,
//                  irq_enable, rx_data, rdrf, ovrn, irq
module acia_rx_feeder
  import acia_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BYTE_CYCLES   = BYTE_CYCLES_DEFAULT,
  parameter bit ALLOW_OVERRUN = 1'b0
) (
  input  logic                 out_clk,
  input  logic                 reset,
  acia_rx_feeder_if.master     bus
);

  rx_state_e             state_q, state_d;
  logic                  fifo_pop_q, fifo_pop_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rdrf_q, rdrf_d;
  logic                  ovrn_q, ovrn_d;
  logic                  irq_q, irq_d;
  logic                  pace_load, pace_dec, pace_zero, pace_last;
  logic                  go;

  byte_pacer #(
    .BYTE_CYCLES (BYTE_CYCLES)
  ) u_pacer (
    .out_clk (out_clk),
    .reset   (reset),
    .clear_i (bus.master_reset),
    .load_i  (pace_load),
    .dec_i   (pace_dec),
    .zero_o  (pace_zero),
    .last_o  (pace_last)
  );

  assign go = bus.fifo_available && pace_zero && (ALLOW_OVERRUN || !rdrf_q);

  always_comb begin
    state_d    = state_q;
    fifo_pop_d = 1'b0;
    rx_data_d  = rx_data_q;
    rdrf_d     = rdrf_q;
    ovrn_d     = ovrn_q;
    pace_load  = 1'b0;
    pace_dec   = 1'b0;

    // A CPU read clears the flags; a capture in the same cycle re-sets rdrf below.
    if (bus.cpu_rd_data) begin
      rdrf_d = 1'b0;
      ovrn_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = POP;
          fifo_pop_d = 1'b1;
        end
      end
      POP: begin
        // FIFO head is still valid here; its pointer moves at this same edge.
        pace_load = 1'b1;
        state_d   = PACE;
        if (!rdrf_q || bus.cpu_rd_data) begin
          rx_data_d = bus.fifo_data;
          rdrf_d    = 1'b1;
        end else begin
          ovrn_d = 1'b1;
        end
      end
      PACE: begin
        pace_dec = 1'b1;
        if (pace_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ACIA master reset drops any in-flight byte but keeps the data register.
    if (bus.master_reset) begin
      state_d    = IDLE;
      fifo_pop_d = 1'b0;
      rx_data_d  = rx_data_q;
      rdrf_d     = 1'b0;
      ovrn_d     = 1'b0;
      pace_load  = 1'b0;
      pace_dec   = 1'b0;
    end

    irq_d = bus.irq_enable && (rdrf_d || ovrn_d);
  end

  always_ff @(posedge out_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fifo_pop_q <= 1'b0;
      rx_data_q  <= '0;
      rdrf_q     <= 1'b0;
      ovrn_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_pop_q <= fifo_pop_d;
      rx_data_q  <= rx_data_d;
      rdrf_q     <= rdrf_d;
      ovrn_q     <= ovrn_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.fifo_pop = fifo_pop_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rdrf     = rdrf_q;
  assign bus.ovrn     = ovrn_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_acia_rx_feeder.sv
// Bench for acia_rx_feeder: one lossless (ALLOW_OVERRUN=0) and one overrun (=1) instance.
// Latency: n/a.
// Backpressure: FIFO models are queues advanced one cycle after a sampled fifo_pop.
module tb_acia_rx_feeder;

  logic out_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 out_clk = ~out_clk;

  acia_rx_feeder_if #(.DATA_WIDTH(8)) i0 ();
  acia_rx_feeder_if #(.DATA_WIDTH(8)) i1 ();

  acia_rx_feeder #(.DATA_WIDTH(8), .BYTE_CYCLES(8), .ALLOW_OVERRUN(1'b0)) dut0 (
    .out_clk (out_clk),
    .reset   (reset),
    .bus     (i0)
  );

  acia_rx_feeder #(.DATA_WIDTH(8), .BYTE_CYCLES(8), .ALLOW_OVERRUN(1'b1)) dut1 (
    .out_clk (out_clk),
    .reset   (reset),
    .bus     (i1)
  );

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tprev   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic update_fifo();
    i0.fifo_available = (fq0.size() != 0);
    i0.fifo_data      = (fq0.size() != 0) ? fq0[0] : 8'h00;
    i1.fifo_available = (fq1.size() != 0);
    i1.fifo_data      = (fq1.size() != 0) ? fq1[0] : 8'h00;
  endtask

  // One clock; FIFO heads advance after a sampled pop, and every rdrf rise
  // is checked against the scoreboard.
  task automatic tick();
    logic p0, p1, r0, r1;
    p0 = i0.fifo_pop;
    p1 = i1.fifo_pop;
    r0 = i0.rdrf;
    r1 = i1.rdrf;
    @(posedge out_clk);
    #1;
    cyc++;
    if (p0) begin
      chk("pop0_nonempty", fq0.size() != 0, 1);
      if (fq0.size() != 0) fq0.delete(0);
    end
    if (p1) begin
      chk("pop1_nonempty", fq1.size() != 0, 1);
      if (fq1.size() != 0) fq1.delete(0);
    end
    update_fifo();
    if (!r0 && i0.rdrf) begin
      chk("sb0_pending", exp0.size() != 0, 1);
      if (exp0.size() != 0) chk("sb0_rx_data", i0.rx_data, exp0.pop_front());
    end
    if (!r1 && i1.rdrf) begin
      chk("sb1_pending", exp1.size() != 0, 1);
      if (exp1.size() != 0) chk("sb1_rx_data", i1.rx_data, exp1.pop_front());
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return i0.fifo_pop;
      1:       return i0.rdrf;
      2:       return i1.fifo_pop;
      default: return i1.rdrf;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!cond(sel) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, cond(sel), 1);
  endtask

  task automatic rd0();
    i0.cpu_rd_data = 1'b1;
    tick();
    i0.cpu_rd_data = 1'b0;
  endtask

  task automatic rd1();
    i1.cpu_rd_data = 1'b1;
    tick();
    i1.cpu_rd_data = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench required to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    i0.master_reset = 1'b0; i0.cpu_rd_data = 1'b0; i0.irq_enable = 1'b0;
    i1.master_reset = 1'b0; i1.cpu_rd_data = 1'b0; i1.irq_enable = 1'b0;
    update_fifo();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_pop0",  i0.fifo_pop, 0);
    chk("rst_rdrf0", i0.rdrf, 0);
    chk("rst_ovrn0", i0.ovrn, 0);
    chk("rst_irq0",  i0.irq, 0);
    chk("rst_rx0",   i0.rx_data, 8'h00);
    chk("rst_rdrf1", i1.rdrf, 0);
    chk("rst_rx1",   i1.rx_data, 8'h00);

    // Scenario 1: lossless holds the second byte while rdrf=1
    fq0.push_back(8'hA5); exp0.push_back(8'hA5);
    fq0.push_back(8'h3C); exp0.push_back(8'h3C);
    update_fifo();
    tick();
    chk("s1_pop_cycle1", i0.fifo_pop, 1);
    tick();
    chk("s1_pop_one_cycle", i0.fifo_pop, 0);
    chk("s1_rdrf_cycle2", i0.rdrf, 1);
    chk("s1_rx_a5", i0.rx_data, 8'hA5);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("s1_no_pop", i0.fifo_pop, 0);
    end
    chk("s1_fifo_holds", fq0.size(), 1);
    rd0();
    wait_for(1, "s1_3c_rdrf_wait");
    rd0();

    // Scenario 2: reads one cycle after each rdrf; pops exactly 8 apart
    fq0.push_back(8'h11); exp0.push_back(8'h11);
    fq0.push_back(8'h22); exp0.push_back(8'h22);
    fq0.push_back(8'h33); exp0.push_back(8'h33);
    update_fifo();
    for (int k = 0; k < 3; k++) begin
      wait_for(0, "s2_pop_wait");
      if (k > 0) chk("s2_pop_spacing", cyc - tprev, 8);
      tprev = cyc;
      wait_for(1, "s2_rdrf_wait");
      tick();
      rd0();
      chk("s2_ovrn_zero", i0.ovrn, 0);
      chk("s2_rdrf_cleared", i0.rdrf, 0);
    end

    // Scenario 3: irq follows rdrf when enabled
    i0.irq_enable = 1'b1;
    fq0.push_back(8'h5A); exp0.push_back(8'h5A);
    update_fifo();
    wait_for(1, "s3_rdrf_wait");
    chk("s3_irq_with_rdrf", i0.irq, 1);
    rd0();
    chk("s3_rdrf_after_rd", i0.rdrf, 0);
    chk("s3_irq_after_rd", i0.irq, 0);
    i0.irq_enable = 1'b0;

    // Scenario 6: master_reset mid-PACE, next byte popped with no residual wait
    fq0.push_back(8'h99); exp0.push_back(8'h99);
    fq0.push_back(8'h77); exp0.push_back(8'h77);
    update_fifo();
    wait_for(0, "s6_pop_wait");
    repeat (3) tick();
    i0.master_reset = 1'b1;
    tick();
    i0.master_reset = 1'b0;
    chk("s6_rdrf_cleared", i0.rdrf, 0);
    chk("s6_ovrn_cleared", i0.ovrn, 0);
    chk("s6_no_pop", i0.fifo_pop, 0);
    chk("s6_rx_kept", i0.rx_data, 8'h99);
    tick();
    chk("s6_pop_immediate", i0.fifo_pop, 1);
    tick();
    chk("s6_rdrf_77", i0.rdrf, 1);
    chk("s6_rx_77", i0.rx_data, 8'h77);

    // Scenario 4: overrun instance, no CPU read
    fq1.push_back(8'h01); exp1.push_back(8'h01);
    fq1.push_back(8'h02);
    update_fifo();
    wait_for(2, "s4_pop1_wait");
    tprev = cyc;
    tick();
    wait_for(2, "s4_pop2_wait");
    chk("s4_pop_spacing", cyc - tprev, 8);
    tick();
    chk("s4_rx_kept", i1.rx_data, 8'h01);
    chk("s4_ovrn_set", i1.ovrn, 1);
    chk("s4_rdrf_set", i1.rdrf, 1);
    rd1();
    chk("s4_rdrf_after_rd", i1.rdrf, 0);
    chk("s4_ovrn_after_rd", i1.ovrn, 0);

    // Scenario 5: CPU read coincides with POP capture; new byte wins
    fq1.push_back(8'h40); exp1.push_back(8'h40);
    fq1.push_back(8'h41);
    fq1.push_back(8'h7E);
    update_fifo();
    wait_for(2, "s5_pop40_wait");
    wait_for(3, "s5_rdrf40_wait");
    wait_for(2, "s5_pop41_wait");
    tick();
    chk("s5_ovrn_before", i1.ovrn, 1);
    chk("s5_rx_40", i1.rx_data, 8'h40);
    wait_for(2, "s5_pop7e_wait");
    i1.cpu_rd_data = 1'b1;
    tick();
    i1.cpu_rd_data = 1'b0;
    chk("s5_rdrf_stays", i1.rdrf, 1);
    chk("s5_rx_7e", i1.rx_data, 8'h7E);
    chk("s5_ovrn_cleared", i1.ovrn, 0);

    // Everything queued has been consumed
    chk("end_fifo0_empty", fq0.size(), 0);
    chk("end_fifo1_empty", fq1.size(), 0);
    chk("end_sb0_empty", exp0.size(), 0);
    chk("end_sb1_empty", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acia_rx_feeder.md
Name: acia_rx_feeder

Overview:
- Consumer stage on the read side of the IO-controller byte FIFO (out_clk domain).
- Pops bytes from the FIFO at no more than one byte per emulated serial character time.
- Presents each byte to the 6850-style ACIA receive side: data register, RDRF, OVRN and IRQ.
- Makes keyboard/MIDI bytes injected by the IO controller arrive with real-UART timing and flags.

Parameters:
- DATA_WIDTH, 8: width of FIFO data and the receive register.
- BYTE_CYCLES, 40960: minimum out_clk cycles between successive deliveries (10 bits at 7812.5 baud at 32 MHz); legal range ≥2.
- ALLOW_OVERRUN, 0:
  - 0: hold off popping while RDRF=1 (lossless back-pressure).
  - 1: pop on schedule regardless; a byte arriving while RDRF=1 is discarded and OVRN is set.

Ports:
- out_clk  in  1  clock; same clock as the FIFO read side.
- reset  in  1  synchronous, active-high.
- fifo_data  in  DATA_WIDTH  FIFO head value; valid while fifo_available=1.
- fifo_available  in  1  FIFO non-empty.
- fifo_pop  out  1  one-cycle pop request; drives the FIFO out_enable.
- master_reset  in  1  ACIA software reset (CR1:0=11); synchronous, one or more cycles.
- cpu_rd_data  in  1  one-cycle pulse; CPU read of the receive data register.
- irq_enable  in  1  receive interrupt enable (CR7).
- rx_data  out  DATA_WIDTH  receive data register.
- rdrf  out  1  receive data register full.
- ovrn  out  1  overrun flag.
- irq  out  1  receive interrupt request.

Behaviour:
- Reset values (reset or master_reset):
  - state=IDLE, fifo_pop=0, pace_cnt=0, rdrf=0, ovrn=0, irq=0.
  - rx_data is cleared on reset only; master_reset keeps rx_data.
  - Neither reset touches the FIFO.
- States: IDLE, POP, PACE.
- IDLE: go = fifo_available && pace_cnt==0 && (ALLOW_OVERRUN || !rdrf).
  - go=1 → POP next cycle; fifo_pop is registered and high for exactly the POP cycle.
- POP, end of cycle:
  - Capture fifo_data: the head is stable because the FIFO pointer advances only at this same edge.
  - If rdrf=0, or rdrf is being cleared by cpu_rd_data this cycle: rx_data ← fifo_data, rdrf ← 1.
  - Otherwise (only possible when ALLOW_OVERRUN=1): byte discarded, ovrn ← 1, rx_data unchanged.
  - pace_cnt ← BYTE_CYCLES-2; state ← PACE.
- PACE: pace_cnt decrements each cycle; at 0 → IDLE. Spacing between fifo_pop pulses is ≥ BYTE_CYCLES cycles.
- Latency: fifo_available rising while IDLE and eligible → fifo_pop high 1 cycle later → rdrf high 2 cycles later.
- cpu_rd_data: clears rdrf and ovrn next edge.
  - Coincides with a POP capture: the new byte wins (rdrf stays 1, ovrn cleared).
- irq is registered: irq ← irq_enable && (rdrf_next || ovrn_next); it updates in the same cycle as the flags.
- pace_cnt width = clog2(BYTE_CYCLES); no wrap (it saturates at 0, decrements only in PACE).
- FIFO going empty in IDLE: stay IDLE, no pop. FIFO never reads past empty because fifo_pop requires fifo_available in the prior cycle.
- master_reset asserted during POP: the pop still reaches the FIFO (already registered), but the byte is dropped, flags are cleared, and state → IDLE.
- ALLOW_OVERRUN=0 and rdrf=1: waits in IDLE indefinitely; fifo_pop stays 0.

Decomposition:
- Package acia_rx_pkg holds:
  - state enum (IDLE/POP/PACE).
  - ACIA status bit positions (RDRF=0, OVRN=5, IRQ=7), used by the register-mux block.
  - default BYTE_CYCLES constant.
- One sub-module, byte_pacer: loadable down-counter with a zero flag, parameterised by BYTE_CYCLES.

Test Plan:
- BYTE_CYCLES=8, ALLOW_OVERRUN=0:
  - Scenario 1: FIFO holds 0xA5; no CPU reads → fifo_pop at cycle 1, rx_data=0xA5 and rdrf=1 at cycle 2; second byte 0x3C stays in FIFO, no further pop.
  - Scenario 2: FIFO holds 0x11,0x22,0x33; cpu_rd_data 1 cycle after each rdrf → pops exactly 8 cycles apart; rx_data sequence 0x11,0x22,0x33; ovrn stays 0.
  - Scenario 3: byte delivered, irq_enable=1 → irq=1 together with rdrf; then cpu_rd_data → rdrf=0 and irq=0 next cycle.
- ALLOW_OVERRUN=1:
  - Scenario 4: FIFO 0x01,0x02, no CPU read → second pop at +8 cycles; rx_data stays 0x01, ovrn=1; then cpu_rd_data → rdrf=0, ovrn=0.
- Scenario 5: cpu_rd_data coincides with the POP capture of 0x7E → rdrf stays 1, rx_data=0x7E.
- Scenario 6: master_reset mid-PACE (pace_cnt=4) → rdrf=0, ovrn=0, state IDLE, pace_cnt=0; next FIFO byte is popped the following cycle with no residual wait.
